// File: rtl/core_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_cfg_pkg
// Description : Shared register offsets, core ID constant and the core
//               start-up sequencer state encoding for core_config_regs.
// Revision    : 1.0 - initial release
// ============================================================================
package core_cfg_pkg;

    // Word offsets inside the 256-byte configuration window
    localparam logic [7:0] c_OFF_CTRL   = 8'h00;
    localparam logic [7:0] c_OFF_GAME   = 8'h04;
    localparam logic [7:0] c_OFF_DSW    = 8'h08;
    localparam logic [7:0] c_OFF_HACK   = 8'h0C;
    localparam logic [7:0] c_OFF_STATUS = 8'h10;
    localparam logic [7:0] c_OFF_ID     = 8'h14;

    // Read-only identification word ("ATH1")
    localparam logic [31:0] c_CORE_ID = 32'h4154_4831;

    // Downloaded-byte counter stops here instead of wrapping
    localparam logic [23:0] c_ROM_COUNT_MAX = 24'hFF_FFFF;

    // Core start-up sequencer states
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/reset_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : reset_stretcher
// Description : Hold counter used while the core is settling. Counts up from
//               zero while enabled; done flags the final cycle of the hold.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_stretcher #(
    parameter int HOLD_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int                 c_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_W-1:0]     c_LAST = c_W'(HOLD_CYCLES - 1);

    logic [c_W-1:0] r_count;

    // Restart from zero on clear, otherwise advance while the hold is active
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/core_config_regs.sv
`default_nettype none
// ============================================================================
// Module      : core_config_regs
// Description : Host-visible configuration registers for the arcade core and
//               the start-up sequencer that holds the core in reset during
//               ROM download and for a settle period afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module core_config_regs
    import core_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hF800_0000,
    parameter logic [7:0]  DEFAULT_GAME = 8'h02,
    parameter logic [15:0] DEFAULT_DSW  = 16'h9CF7,
    parameter logic [7:0]  DEFAULT_HACK = 8'h01,
    parameter int          HOLD_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cfg_addr,
    input  logic        cfg_wr,
    input  logic [31:0] cfg_wr_data,
    input  logic        cfg_rd,
    output logic [31:0] cfg_rd_data,
    output logic        cfg_rd_valid,
    input  logic        rom_loading,
    input  logic        rom_wr,
    output logic        core_reset_n,
    output logic        pause_cpu,
    output logic [7:0]  game,
    output logic [15:0] dsw,
    output logic [7:0]  hack_settings,
    output logic [2:0]  layer_ena_dbg,
    output logic [1:0]  state_o
);

    cfg_state_e  r_state;
    cfg_state_e  w_state_next;
    logic        r_pause;
    logic [7:0]  r_game;
    logic [15:0] r_dsw;
    logic [7:0]  r_hack;
    logic [2:0]  r_layer;
    logic [23:0] r_rom_count;
    logic        r_rom_loading_d;

    // Address decode: only the upper 24 bits select the window
    logic       w_hit;
    logic [7:0] w_off;
    assign w_hit = (cfg_addr[31:8] == BASE_ADDR[31:8]);
    assign w_off = cfg_addr[7:0];

    logic w_wr_ctrl, w_wr_game, w_wr_dsw, w_wr_hack;
    assign w_wr_ctrl = cfg_wr & w_hit & (w_off == c_OFF_CTRL);
    assign w_wr_game = cfg_wr & w_hit & (w_off == c_OFF_GAME);
    assign w_wr_dsw  = cfg_wr & w_hit & (w_off == c_OFF_DSW);
    assign w_wr_hack = cfg_wr & w_hit & (w_off == c_OFF_HACK);

    // Sequencer events. A new download wins over everything else; HOLD and
    // RUN also react to the level so a download already in progress is seen.
    logic w_load_start, w_soft_reset, w_game_change, w_hold_done, w_settle_start;
    logic w_stretch_done, w_pause_next;

    assign w_load_start  = rom_loading &
                           (~r_rom_loading_d | (r_state == HOLD) | (r_state == RUN));
    assign w_soft_reset  = w_wr_ctrl & cfg_wr_data[1];
    assign w_game_change = w_wr_game & (cfg_wr_data[7:0] != r_game) & (r_state == RUN);
    assign w_hold_done   = (r_state == SETTLE) & w_stretch_done;
    assign w_pause_next  = w_wr_ctrl ? cfg_wr_data[0] : r_pause;

    // Next-state selection for the start-up sequencer
    always_comb begin
        w_state_next = r_state;
        if (w_load_start) begin
            w_state_next = LOAD;
        end else if (w_soft_reset) begin
            w_state_next = SETTLE;
        end else begin
            case (r_state)
                HOLD:    w_state_next = HOLD;
                LOAD:    if (!rom_loading)  w_state_next = SETTLE;
                SETTLE:  if (w_hold_done)   w_state_next = RUN;
                RUN:     if (w_game_change) w_state_next = SETTLE;
                default: w_state_next = HOLD;
            endcase
        end
    end

    // Any entry into SETTLE (including a soft reset while settling) restarts the hold
    assign w_settle_start = (w_state_next == SETTLE) &
                            ((r_state != SETTLE) | w_soft_reset);

    reset_stretcher #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_reset_stretcher (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_settle_start),
        .enable (r_state == SETTLE),
        .done   (w_stretch_done)
    );

    // Sequencer state plus the core control outputs derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HOLD;
            core_reset_n <= 1'b0;
            pause_cpu    <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            core_reset_n <= (w_state_next == RUN);
            pause_cpu    <= w_pause_next | (w_state_next != RUN);
        end
    end

    // Writable configuration registers; soft_reset is a strobe and is not stored
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause <= 1'b0;
            r_game  <= DEFAULT_GAME;
            r_dsw   <= DEFAULT_DSW;
            r_hack  <= DEFAULT_HACK;
            r_layer <= 3'b111;
        end else begin
            r_pause <= w_pause_next;
            if (w_wr_game) r_game <= cfg_wr_data[7:0];
            if (w_wr_dsw)  r_dsw  <= cfg_wr_data[15:0];
            if (w_wr_hack) begin
                r_hack  <= cfg_wr_data[7:0];
                r_layer <= cfg_wr_data[10:8];
            end
        end
    end

    // Download byte counter: cleared on each new download, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_count     <= '0;
            r_rom_loading_d <= 1'b0;
        end else begin
            r_rom_loading_d <= rom_loading;
            if (w_load_start) begin
                r_rom_count <= '0;
            end else if ((r_state == LOAD) && rom_wr && (r_rom_count != c_ROM_COUNT_MAX)) begin
                r_rom_count <= r_rom_count + 24'd1;
            end
        end
    end

    // Read mux: uses current register values so a same-cycle write is not visible
    logic [31:0] w_rd_mux;
    always_comb begin
        w_rd_mux = 32'h0;
        if (w_hit) begin
            case (w_off)
                c_OFF_CTRL:   w_rd_mux = {31'h0, r_pause};
                c_OFF_GAME:   w_rd_mux = {24'h0, r_game};
                c_OFF_DSW:    w_rd_mux = {16'h0, r_dsw};
                c_OFF_HACK:   w_rd_mux = {21'h0, r_layer, r_hack};
                c_OFF_STATUS: w_rd_mux = {r_rom_count, 6'b0, r_state};
                c_OFF_ID:     w_rd_mux = c_CORE_ID;
                default:      w_rd_mux = 32'h0;
            endcase
        end
    end

    // Registered read response, one cycle after the strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rd_valid <= 1'b0;
            cfg_rd_data  <= 32'h0;
        end else begin
            cfg_rd_valid <= cfg_rd;
            cfg_rd_data  <= cfg_rd ? w_rd_mux : 32'h0;
        end
    end

    assign game          = r_game;
    assign dsw           = r_dsw;
    assign hack_settings = r_hack;
    assign layer_ena_dbg = r_layer;
    assign state_o       = r_state;

    // Write-data bits with no destination in the register map
    logic w_unused;
    assign w_unused = &{1'b0, cfg_wr_data[31:16]};

endmodule
`default_nettype wire
